dmem_responder: RTL

//  Memory-side responder for the core's data-memory port (MemWrite/DataAdr/WriteData).

---
 rtl/dmem_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM behind a request/ready handshake with a fixed
// response latency, plus a sticky store-watch checker that drives done/pass.
module dmem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] WATCH_ADDR  = 32'd100,
    parameter logic [31:0] WATCH_DATA  = 32'd7,
    parameter logic [31:0] IGNORE_ADDR = 32'd96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr,
    output logic        done,
    output logic        pass
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [31:0] Limit   = 32'(4 * DEPTH);
    localparam logic [3:0]  LatInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          accept;
    logic          adr_err;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH];

    assign idx     = DataAdr[AW+1:2];
    assign adr_err = (DataAdr[1:0] != 2'b00) || (DataAdr >= Limit);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (MemWrite || MemRead) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = LatInit;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request is latched at acceptance; a store wins over a simultaneous load.
    always_comb begin
        err_d   = err_q;
        rdata_d = rdata_q;
        done_d  = done_q;
        pass_d  = pass_q;
        if (accept) begin
            err_d   = adr_err;
            rdata_d = (!MemWrite && !adr_err) ? mem[idx] : 32'd0;
            if (MemWrite && !done_q) begin
                if (DataAdr == WATCH_ADDR && WriteData == WATCH_DATA) begin
                    done_d = 1'b1;
                    pass_d = 1'b1;
                end else if (DataAdr != IGNORE_ADDR) begin
                    done_d = 1'b1;
                    pass_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // RAM is deliberately outside the reset domain so accepted stores survive a reset.
    always_ff @(posedge clk) begin
        if (accept && MemWrite && !adr_err) begin
            mem[idx] <= WriteData;
        end
    end

    assign MemReady = (state_q == StResp);
    assign MemErr   = MemReady & err_q;
    assign ReadData = MemReady ? rdata_q : 32'd0;
    assign done     = done_q;
    assign pass     = pass_q;

endmodule
